// File: rtl/ha_result_collector_if.sv
// ha_result_collector_if
//   Handshake bundle between the half-adder stage, the result collector and
//   the downstream checker/display logic.
//   Signals:
//     in_valid, in_s, in_c  : one sum/carry bit pair per cycle from the half adder
//     in_ready              : collector can take a pair this cycle
//     out_valid, out_ready  : completed-frame handshake towards the next stage
//     out_sum, out_carry    : assembled frame, first accepted pair in bit 0
//     out_ones              : number of set bits in out_carry
//     out_parity            : XOR of out_sum (only with HA_COLLECT_PARITY_EN)
//   Modports: slave = collector view, master = producer/consumer (bench) view.
interface ha_result_collector_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_s;
  logic             in_c;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [WIDTH-1:0] out_carry;
  logic [CNT_W-1:0] out_ones;
`ifdef HA_COLLECT_PARITY_EN
  logic             out_parity;
`endif

  modport slave (
    input  in_valid, in_s, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ones
`ifdef HA_COLLECT_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output in_valid, in_s, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ones
`ifdef HA_COLLECT_PARITY_EN
    , input out_parity
`endif
  );
endinterface

// File: rtl/ha_result_collector.sv
// ha_result_collector
//   Collects WIDTH consecutive sum/carry bit pairs from the half adder (LSB
//   first) into parallel sum and carry words plus a popcount of the carry
//   word, and offers each completed frame on a valid/ready output.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : ha_result_collector_if.slave (input pair handshake, frame output)
//   Optional feature: define HA_COLLECT_PARITY_EN to add bus.out_parity,
//   the XOR of all out_sum bits, loaded together with the frame.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   COLLECT | accepting pairs, in_ready=1, out_valid=0
//   HOLD    | frame presented, in_ready=0, waiting for out_ready
module ha_result_collector #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  ha_result_collector_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_nxt;
  logic [IDX_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q, carry_q;
  logic [WIDTH-1:0] sum_nxt, carry_nxt;
  logic [CNT_W-1:0] ones_nxt;
  logic [WIDTH-1:0] out_sum_q, out_carry_q;
  logic [CNT_W-1:0] out_ones_q;
  logic             accept, last;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt    = state_q;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    accept       = 1'b0;
    last         = 1'b0;
    case (state_q)
      COLLECT: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        last         = accept && (cnt_q == IDX_W'(WIDTH - 1));
        if (last) state_nxt = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Frame word including the pair accepted this cycle, so the output load
  // and popcount on the final edge see all WIDTH bits.
  always_comb begin
    sum_nxt          = sum_q;
    carry_nxt        = carry_q;
    sum_nxt[cnt_q]   = bus.in_s;
    carry_nxt[cnt_q] = bus.in_c;
    ones_nxt         = '0;
    for (int i = 0; i < WIDTH; i++) ones_nxt = ones_nxt + CNT_W'(carry_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      out_sum_q   <= '0;
      out_carry_q <= '0;
      out_ones_q  <= '0;
    end else if (accept) begin
      sum_q   <= sum_nxt;
      carry_q <= carry_nxt;
      if (last) begin
        cnt_q       <= '0;
        out_sum_q   <= sum_nxt;
        out_carry_q <= carry_nxt;
        out_ones_q  <= ones_nxt;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.out_sum   = out_sum_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_ones  = out_ones_q;

`ifdef HA_COLLECT_PARITY_EN
  logic out_parity_q;

  always_ff @(posedge clk) begin
    if (!rst_n)         out_parity_q <= 1'b0;
    else if (last)      out_parity_q <= ^sum_nxt;
  end

  assign bus.out_parity = out_parity_q;
`endif
endmodule

// File: tb/tb_ha_result_collector.sv
// tb_ha_result_collector
//   Directed-vector bench for ha_result_collector (WIDTH=8). The stimulus
//   process pushes hand-computed frames into a queue; a monitor process pops
//   and compares whenever a frame is handed off downstream.
module tb_ha_result_collector;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic [3:0]   ones;
    logic         par;
    int           rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   started = 1'b0;
  exp_t q[$];

  ha_result_collector_if #(.WIDTH(W)) bus ();

  ha_result_collector #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one pair and keep it up until it is offered while in_ready=1.
  task automatic send_pair(input logic s, input logic c);
    int tries;
    tries = 0;
    forever begin
      @(posedge clk); #2;
      bus.in_valid = 1'b1;
      bus.in_s     = s;
      bus.in_c     = c;
      if (bus.in_ready) break;
      tries++;
      if (tries > 50) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
    end
  endtask

  // gaps[k]=1 inserts one in_valid=0 cycle after pair k.
  task automatic send_frame(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W-1:0] gaps,
                            input logic [W-1:0] esum, input logic [W-1:0] ecarry,
                            input logic [3:0] eones, input logic epar);
    exp_t e;
    for (int k = 0; k < W; k++) begin
      send_pair(s[k], c[k]);
      if (k == W - 1) begin
        e.sum = esum; e.carry = ecarry; e.ones = eones; e.par = epar;
        e.rise = cyc + 1;
        q.push_back(e);
      end else if (gaps[k]) begin
        idle(1);
      end
    end
  endtask

  // Monitor
  logic         prev_valid = 1'b0;
  logic         expect_drop = 1'b0;
  logic         stable_ok = 1'b1;
  logic [W-1:0] cap_sum, cap_carry;
  logic [3:0]   cap_ones;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !started) begin
      prev_valid  = 1'b0;
      expect_drop = 1'b0;
    end else begin
      if (expect_drop) begin
        check("valid_drop_after_accept", 32'(bus.out_valid), 0);
        expect_drop = 1'b0;
      end
      check("in_ready_state_only", 32'(bus.in_ready), 32'(!bus.out_valid));
      if (bus.out_valid && !prev_valid) begin
        if (q.size() == 0) check("unexpected_frame", 1, 0);
        else               check("frame_latency_cycle", 32'(cyc), 32'(q[0].rise));
        cap_sum   = bus.out_sum;
        cap_carry = bus.out_carry;
        cap_ones  = bus.out_ones;
        stable_ok = 1'b1;
      end else if (bus.out_valid) begin
        if (bus.out_sum !== cap_sum || bus.out_carry !== cap_carry || bus.out_ones !== cap_ones)
          stable_ok = 1'b0;
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("out_sum", 32'(bus.out_sum), 32'(e.sum));
        check("out_carry", 32'(bus.out_carry), 32'(e.carry));
        check("out_ones", 32'(bus.out_ones), 32'(e.ones));
        check("hold_stable", 32'(stable_ok), 1);
`ifdef HA_COLLECT_PARITY_EN
        check("out_parity", 32'(bus.out_parity), 32'(e.par));
`endif
        expect_drop = 1'b1;
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    int waited;
    bus.in_valid  = 1'b1;
    bus.in_s      = 1'b0;
    bus.in_c      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held for 3 edges with valid pairs offered.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      bus.in_s = 1'($urandom_range(0, 1));
      bus.in_c = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_sum", 32'(bus.out_sum), 0);
    check("rst_out_carry", 32'(bus.out_carry), 0);
    check("rst_out_ones", 32'(bus.out_ones), 0);
`ifdef HA_COLLECT_PARITY_EN
    check("rst_out_parity", 32'(bus.out_parity), 0);
`endif
    started = 1'b1;

    // Basic frame: s=1,0,1,1,0,0,1,0 c=0,1,0,0,1,1,0,1 (LSB first).
    send_frame(8'b0100_1101, 8'b1011_0010, 8'h00, 8'h4D, 8'hB2, 4'd4, 1'b0);
    idle(3);

    // Same pairs with gaps after pair 2 and pair 5 (k=1, k=4).
    send_frame(8'b0100_1101, 8'b1011_0010, 8'b0001_0010, 8'h4D, 8'hB2, 4'd4, 1'b0);
    idle(3);

    // Backpressure: all-ones carry, out_ready low, in_valid held high.
    bus.out_ready = 1'b0;
    send_frame(8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 4'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      bus.in_valid = 1'b1;
      bus.in_s     = 1'($urandom_range(0, 1));
      bus.in_c     = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_s      = 1'b1;
    bus.in_c      = 1'b1;
    // Fresh frame right after release; s=c=1 pairs included.
    send_frame(8'hA5, 8'h3C, 8'h00, 8'hA5, 8'h3C, 4'd4, 1'b0);
    idle(3);

    // Reset mid-frame after 3 accepted (1,1) pairs.
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    send_frame(8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 4'd0, 1'b1);
    idle(2);

    // Boundary: single carry in the top bit, sum all ones.
    send_frame(8'hFF, 8'h80, 8'h00, 8'hFF, 8'h80, 4'd1, 1'b0);

    waited = 0;
    while (q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    idle(3);
    check("frames_pending", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ha_result_collector.md
Name: ha_result_collector

Overview:
- Downstream consumer of the half_adder stage.
- Accepts the per-cycle sum/carry bit pair (s, c) through a valid/ready handshake.
- Assembles WIDTH consecutive pairs, LSB first, into parallel sum and carry words, plus a count of set carry bits.
- Presents each completed frame on a valid/ready output for the next stage (checker or display logic).

Parameters:
- WIDTH, 8, number of bit pairs per frame; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of out_ones. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_s/in_c carry a valid pair this cycle.
- in_s  input  1  sum bit from half_adder.
- in_c  input  1  carry bit from half_adder.
- in_ready  output  1  collector can accept a pair this cycle.
- out_valid  output  1  completed frame present.
- out_ready  input  1  downstream accepts the frame.
- out_sum  output  WIDTH  assembled sum bits; first accepted pair in bit 0.
- out_carry  output  WIDTH  assembled carry bits; first accepted pair in bit 0.
- out_ones  output  CNT_W  number of 1s in out_carry.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=COLLECT, bit counter=0, out_valid=0, out_sum=0, out_carry=0, out_ones=0. in_ready=1 in the first cycle after reset releases.
- States: COLLECT, HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - A pair is accepted on a rising edge when in_valid=1. Accepted pair k (k=0..WIDTH-1) lands in bit k of the internal sum/carry registers. The counter increments.
  - in_valid=0 cycles are ignored: no shift, no count.
- COLLECT -> HOLD: on the edge that accepts pair WIDTH-1. On that same edge:
  - out_sum/out_carry are loaded with the full frame.
  - out_ones is loaded with the carry popcount.
  - out_valid=1 from the next cycle; latency is 1 clock after the last accepted pair.
  - The counter clears.
- HOLD:
  - in_ready=0; in_valid is ignored and nothing is lost or accepted.
  - out_sum/out_carry/out_ones are held stable while out_valid=1 and out_ready=0.
- HOLD -> COLLECT: on an edge with out_ready=1. out_valid=0 and in_ready=1 from the next cycle. Output words keep their last value; they are don't-care while out_valid=0.
- Simultaneous events: out_ready=1 and in_valid=1 in the same HOLD cycle: the frame is released, the input pair is NOT accepted (in_ready was 0). No bypass path.
- in_ready is combinational from state only. It must not depend on in_valid or out_ready.
- in_s=in_c=1 (impossible from a half adder) is accepted and stored as given. No error flag.
- Reset mid-frame: partial bits are discarded and the counter returns to 0. The next frame starts at bit 0.
- Reset during HOLD: out_valid drops the cycle after the reset edge and the frame is lost.
- out_ones is computed from the full carry word at load time. No incremental counter is required, but the result must match the popcount exactly.

Optional Feature:
- Macro: HA_COLLECT_PARITY_EN.
- Defined:
  - Adds output port out_parity (output, 1): XOR of all out_sum bits.
  - Loaded on the same edge as out_sum, reset to 0, held during HOLD like the other outputs.
- Undefined: port absent, no parity logic. All other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with in_valid=1 and random in_s/in_c -> in_ready=1, out_valid=0, out_sum=0, out_carry=0, out_ones=0; no bit is counted.
- Basic frame (WIDTH=8), out_ready=1:
  - Stimulus: feed s=1,0,1,1,0,0,1,0 and c=0,1,0,0,1,1,0,1 on 8 consecutive valid cycles.
  - Required: out_valid=1 exactly 1 cycle after the 8th accept, with out_sum=8'h4D, out_carry=8'hB2, out_ones=4.
- Gaps: same 8 pairs with in_valid=0 inserted after pairs 2 and 5 -> identical result (4D/B2/4), out_valid only after the 8th valid pair.
- Backpressure: complete a frame, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable all 5 cycles. Raise out_ready -> out_valid=0 next cycle; the next 8 pairs form a fresh, correct frame.
- Reset mid-frame: accept 3 pairs (s=1,c=1), pulse rst_n=0 for 1 edge, then send 8 pairs with s=1 only at pair 0 and c=0 throughout -> out_sum=8'h01, out_carry=8'h00, out_ones=0.
- With HA_COLLECT_PARITY_EN: frame out_sum=8'h4D -> out_parity=0; frame out_sum=8'h01 -> out_parity=1. Without the macro, the design compiles with no out_parity port.
